// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache/memory constants and the memory FSM state type
package cache_pkg;
  localparam int ADDR_BITS      = 12;
  localparam int OFFSET_BITS    = 2;
  localparam int CACHELINE_BITS = 32;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int CPU_CORES      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;
endpackage

// File: rtl/main_memory_array.sv
// rtl/main_memory_array.sv - line storage: synchronous write, combinational read, zero at power-up
module main_memory_array
  import cache_pkg::*;
(
  input  logic                      clk,
  input  logic                      we,
  input  logic [LINE_ADDR_BITS-1:0] addr,
  input  logic [CACHELINE_BITS-1:0] wdata,
  output logic [CACHELINE_BITS-1:0] rdata
);
  // Power-up contents come from the declaration; reset never touches the array.
  logic [CACHELINE_BITS-1:0] mem_q [2**LINE_ADDR_BITS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency line memory; MAIN_MEMORY_WRITE_ACK_EN adds a write response
module main_memory
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [LINE_ADDR_BITS-1:0] mem_req_addr,
  input  logic [CACHELINE_BITS-1:0] mem_req_data,
  output logic                      mem_req_ready,
  output logic                      mem_resp_valid,
  output logic [CACHELINE_BITS-1:0] mem_resp_data
);
`ifdef MAIN_MEMORY_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  mem_state_e                state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      resp_pend_q, resp_pend_d;
  logic [CACHELINE_BITS-1:0] hold_q, hold_d;
  logic [CACHELINE_BITS-1:0] resp_data_q, resp_data_d;
  logic [CACHELINE_BITS-1:0] arr_rdata;
  logic                      accept;

  assign accept = mem_req_valid && (state_q == S_IDLE);

  main_memory_array u_array (
    .clk   (clk),
    .we    (accept && mem_req_rw),
    .addr  (mem_req_addr),
    .wdata (mem_req_data),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_pend_d = resp_pend_q;
    hold_d      = hold_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d       = 8'(MEM_LATENCY - 1);
          resp_pend_d = !mem_req_rw || WRITE_ACK;
          hold_d      = mem_req_rw ? mem_req_data : arr_rdata;
          state_d     = (resp_pend_d && MEM_LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        // Responding ops leave one cycle early so the RESP cycle completes the latency;
        // silent writes stay busy that extra cycle instead.
        if (resp_pend_q && cnt_q <= 8'd1)        state_d = S_RESP;
        else if (!resp_pend_q && cnt_q == 8'd0) state_d = S_IDLE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The visible data only changes when a new response begins.
    if (state_d == S_RESP && state_q != S_RESP)
      resp_data_d = (state_q == S_IDLE) ? hold_d : hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      resp_pend_q <= 1'b0;
      hold_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_pend_q <= resp_pend_d;
      hold_q      <= hold_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign mem_req_ready  = (state_q == S_IDLE);
  assign mem_resp_valid = (state_q == S_RESP);
  assign mem_resp_data  = resp_data_q;
endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - scoreboard bench for main_memory (latency 4 and latency 1 instances)
module tb_main_memory;
  localparam int LAT = 4;
`ifdef MAIN_MEMORY_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req_valid = 1'b0, mem_req_rw = 1'b0;
  logic [9:0]  mem_req_addr = '0;
  logic [31:0] mem_req_data = '0;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic        v1 = 1'b0, rw1 = 1'b0;
  logic [9:0]  a1 = '0;
  logic [31:0] d1 = '0;
  logic        rdy1, rv1;
  logic [31:0] rd1;

  int          tests = 0, fails = 0, cyc = 0;
  exp_t        sb[$];
  logic [31:0] model [1024];
  int          acc[$];

  main_memory #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  main_memory #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_req_valid(v1), .mem_req_rw(rw1),
    .mem_req_addr(a1), .mem_req_data(d1), .mem_req_ready(rdy1),
    .mem_resp_valid(rv1), .mem_resp_data(rd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (mem_resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", {31'd0, mem_resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", mem_resp_data, e.data);
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic req(input logic rw, input logic [9:0] addr, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    while (!mem_req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready", {31'd0, mem_req_ready}, 32'd1);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr; mem_req_data = data;
    if (!rw || ACK) sb.push_back('{rw ? data : model[addr], cyc + LAT});
    if (rw) model[addr] = data;
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'($urandom);
    mem_req_addr  = 10'($urandom);
    mem_req_data  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !mem_req_ready) && n < 100) begin @(negedge clk); n++; end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, mem_req_ready}, 32'd1);
    chk("rst_valid", {31'd0, mem_resp_valid}, 32'd0);
    chk("rst_data", mem_resp_data, 32'd0);
    reset_n = 1'b1;

    req(1'b0, 10'h3A5, 32'h0); drain();
    req(1'b1, 10'h123, 32'hDEADBEEF); drain();
    req(1'b0, 10'h123, 32'h0); drain();
    repeat (3) @(negedge clk);
    chk("resp_data_hold", mem_resp_data, 32'hDEADBEEF);

    req(1'b1, 10'h000, 32'h11111111);
    req(1'b1, 10'h3FF, 32'h22222222);
    req(1'b0, 10'h000, 32'h0);
    req(1'b0, 10'h3FF, 32'h0); drain();

    // Continuous valid with alternating addresses; only ready cycles accept.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      mem_req_valid = 1'b1; mem_req_rw = 1'b0;
      mem_req_addr  = (i % 2 == 0) ? 10'h123 : 10'h3FF;
      if (mem_req_ready) begin
        sb.push_back('{model[mem_req_addr], cyc + LAT});
        acc.push_back(cyc);
      end
    end
    @(negedge clk); mem_req_valid = 1'b0;
    drain();
    chk("stream_accepts", acc.size(), 32'd5);
    for (int i = 1; i < acc.size(); i++) chk("stream_spacing", acc[i] - acc[i-1], LAT + 1);

    // Reset two cycles into a read aborts it; the earlier write survives.
    req(1'b1, 10'h010, 32'hCAFEF00D); drain();
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 10'h010;
    @(posedge clk); #1 mem_req_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, mem_resp_valid}, 32'd0);
    chk("midrst_data", mem_resp_data, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", {31'd0, mem_req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    req(1'b0, 10'h010, 32'h0); drain();

    // Latency-1 instance.
    @(negedge clk);
    v1 = 1'b1; rw1 = 1'b1; a1 = 10'h005; d1 = 32'h5A5A5A5A;
    @(posedge clk); #1 v1 = 1'b0;
    @(negedge clk);
    chk("l1_wr_valid", {31'd0, rv1}, {31'd0, ACK});
    chk("l1_wr_ready", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("l1_wr_ready_again", {31'd0, rdy1}, 32'd1);
    v1 = 1'b1; rw1 = 1'b0; a1 = 10'h005;
    @(posedge clk); #1 v1 = 1'b0;
    @(negedge clk);
    chk("l1_rd_valid", {31'd0, rv1}, 32'd1);
    chk("l1_rd_data", rd1, 32'h5A5A5A5A);
    @(negedge clk);
    chk("l1_rd_valid_drop", {31'd0, rv1}, 32'd0);
    chk("l1_rd_ready", {31'd0, rdy1}, 32'd1);

    repeat (4) @(negedge clk);
    chk("final_pending", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter MEM_LATENCY, default 4, cycles from request acceptance to response (legal range 1..255).
REQ-002 Constants ADDR_BITS=12, OFFSET_BITS=2, CACHELINE_BITS=32, from the shared package; LINE_ADDR_BITS = ADDR_BITS-OFFSET_BITS = 10.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req_valid  input  1  request present.
REQ-006 mem_req_rw  input  1  0 = read line, 1 = write line.
REQ-007 mem_req_addr  input  LINE_ADDR_BITS  cache-line address (no byte offset).
REQ-008 mem_req_data  input  CACHELINE_BITS  write data.
REQ-009 mem_req_ready  output  1  memory can accept a request this cycle.
REQ-010 mem_resp_valid  output  1  one-cycle response strobe.
REQ-011 mem_resp_data  output  CACHELINE_BITS  read data, or written data on a write ack.

Function
REQ-012 The storage array SHALL hold 2**LINE_ADDR_BITS lines of CACHELINE_BITS bits; every line is zero at time 0.
REQ-013 FSM states: IDLE, BUSY, RESP; mem_req_ready = 1 only in IDLE.
REQ-014 A request is accepted on a rising edge with mem_req_valid && mem_req_ready; IDLE -> BUSY; a latency counter loads MEM_LATENCY-1.
REQ-015 Accepted write: the array line is updated on the acceptance edge itself.
REQ-016 Accepted read: the line is captured into a response register on the acceptance edge.
REQ-017 BUSY decrements the counter each cycle; at zero -> RESP; with MEM_LATENCY=1, BUSY lasts 0 cycles (IDLE -> RESP directly).
REQ-018 RESP drives mem_resp_valid=1 for exactly one cycle, then returns to IDLE.
REQ-019 mem_resp_valid SHALL first be high MEM_LATENCY cycles after the acceptance edge.
REQ-020 Only one outstanding request; mem_req_valid while not ready is ignored and does not queue.
REQ-021 mem_req_* inputs are sampled only at acceptance; later changes have no effect.
REQ-022 mem_resp_data holds its value until the next response; it is zero after reset.
REQ-023 A read following a write to the same line returns the written data.
REQ-024 Address range is the full LINE_ADDR_BITS space with no wrap or aliasing; line 0 and line 1023 are independent.

Reset
REQ-025 While reset_n=0: state=IDLE, counter=0, mem_req_ready=1 after release, mem_resp_valid=0, mem_resp_data=0.
REQ-026 Reset mid-transaction aborts the pending response; a write already accepted stays committed; array contents are never cleared by reset.

Configuration
REQ-027 With macro MAIN_MEMORY_WRITE_ACK_EN defined, writes produce the RESP strobe with mem_resp_data = written data.
REQ-028 Without MAIN_MEMORY_WRITE_ACK_EN, writes produce no mem_resp_valid; the FSM still spends MEM_LATENCY cycles busy, then returns to IDLE, skipping RESP.

Structure
REQ-029 The shared package (cache_pkg) holds ADDR_BITS, OFFSET_BITS, CACHELINE_BITS, LINE_ADDR_BITS, CPU_CORES=4, and the FSM state enum typedef.
REQ-030 One sub-module, main_memory_array: single-port synchronous write, combinational read, zero-initialized.

Verification
REQ-031 After reset, read line 0x3A5 -> mem_resp_valid one cycle, exactly 4 cycles after acceptance, data 0x00000000.
REQ-032 Write 0xDEADBEEF to 0x123, then read 0x123 -> read returns 0xDEADBEEF; with ACK_EN, the write ack carries 0xDEADBEEF.
REQ-033 Hold mem_req_valid high continuously with alternating addresses -> a new acceptance no earlier than every MEM_LATENCY+1 cycles; requests presented while not ready are dropped.
REQ-034 Write 0x11111111 to 0x000 and 0x22222222 to 0x3FF, read both -> each returns its own value.
REQ-035 Accept a read of 0x010, assert reset_n=0 at cycle 2 -> no mem_resp_valid, ready after release; a prior write to 0x010 persists.
REQ-036 MEM_LATENCY=1: read accepted -> mem_resp_valid on the next cycle, ready again the cycle after.
